// File: rtl/pkt_sink_checker.sv
// NoC receive-side sink: throttled ready/valid intake with destination and per-source sequence checks.
// Optional sequence table and order check enabled by defining PKT_SINK_SEQ_CHECK_EN.
module pkt_sink_checker #(
    parameter int xcord        = 0,
    parameter int ycord        = 0,
    parameter int X            = 4,
    parameter int Y            = 4,
    parameter int dest_x       = 2,
    parameter int dest_y       = 2,
    parameter int source_x     = 8,
    parameter int source_y     = 8,
    parameter int data_width   = 240,
    parameter int total_width  = dest_x + dest_y + source_x + source_y + data_width,
    parameter int num_of_pckts = 48,
    parameter int READY_PERIOD = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [total_width-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [31:0]            o_rx_count,
    output logic [31:0]            o_misroute_cnt,
    output logic [31:0]            o_order_err_cnt,
    output logic                   o_err,
    output logic                   o_done
);

    localparam int DY_LO = dest_x;
    localparam int SX_LO = dest_x + dest_y;
    localparam int SY_LO = SX_LO + source_x;
    localparam int PL_LO = SY_LO + source_y;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [31:0] tc_q, tc_d;
    logic        ready_q, ready_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] mis_q;
    logic [31:0] ord_q;
    logic        err_q;
    logic        done_q;

    logic [dest_x-1:0]   dst_x;
    logic [dest_y-1:0]   dst_y;
    logic [source_x-1:0] src_x;
    logic [source_y-1:0] src_y;
    logic                accept;
    logic                misroute;
    logic                order_err;
    logic                unused_data;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign dst_x       = i_data[DY_LO-1:0];
    assign dst_y       = i_data[SX_LO-1:DY_LO];
    assign src_x       = i_data[SY_LO-1:SX_LO];
    assign src_y       = i_data[PL_LO-1:SY_LO];
    assign unused_data = ^i_data;

    assign accept   = i_valid && ready_q;
    assign misroute = (dst_x != dest_x'(xcord)) || (dst_y != dest_y'(ycord)) ||
                      (32'(src_x) >= 32'(X)) || (32'(src_y) >= 32'(Y));

`ifdef PKT_SINK_SEQ_CHECK_EN
    localparam int NSRC = X * Y;
    localparam int IW   = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] valid_q;
    logic [31:0]     last_q [NSRC];
    logic [IW-1:0]   idx;
    logic [31:0]     seq;
    logic            ent_valid;
    logic [31:0]     ent_last;
    logic            tbl_wr;

    assign seq       = i_data[PL_LO+31:PL_LO];
    assign idx       = IW'(32'(src_y) * 32'(X) + 32'(src_x));
    assign ent_valid = valid_q[idx];
    assign ent_last  = last_q[idx];
    assign order_err = accept && !misroute && ent_valid && (seq <= ent_last);
    assign tbl_wr    = accept && !misroute && (!ent_valid || (seq > ent_last));

    // Table lives in flops, so a write on this edge is already visible to next cycle's read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < NSRC; i++) last_q[i] <= '0;
        end else if (tbl_wr) begin
            valid_q[idx] <= 1'b1;
            last_q[idx]  <= seq;
        end
    end
`else
    assign order_err = 1'b0;
`endif

    always_comb begin
        rx_d    = accept ? sat_inc(rx_q) : rx_q;
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !start_q) state_d = RUN;
            RUN:     if (rx_d >= 32'(num_of_pckts)) state_d = DONE;
            default: state_d = DONE;
        endcase

        tc_d = '0;
        if (state_q != IDLE && READY_PERIOD != 0 && tc_q != 32'(READY_PERIOD - 1))
            tc_d = tc_q + 32'd1;

        // Ready is registered: computed from next state and next throttle count.
        ready_d = (state_d != IDLE) &&
                  (READY_PERIOD == 0 || tc_d != 32'(READY_PERIOD - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            tc_q    <= '0;
            ready_q <= 1'b0;
            rx_q    <= '0;
            mis_q   <= '0;
            ord_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            tc_q    <= tc_d;
            ready_q <= ready_d;
            rx_q    <= rx_d;
            done_q  <= (state_d == DONE);
            if (accept && misroute) mis_q <= sat_inc(mis_q);
            if (order_err)          ord_q <= sat_inc(ord_q);
            if ((accept && misroute) || order_err || (accept && state_q == DONE))
                err_q <= 1'b1;
        end
    end

    assign o_ready         = ready_q;
    assign o_rx_count      = rx_q;
    assign o_misroute_cnt  = mis_q;
    assign o_order_err_cnt = ord_q;
    assign o_err           = err_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_pkt_sink_checker.sv
// Directed self-checking bench for pkt_sink_checker: three instances (no throttle, throttle 4, short run).
module tb_pkt_sink_checker;

    localparam int TW = 260;

`ifdef PKT_SINK_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic clk;
    logic rstn;

    logic          start_a, valid_a, ready_a, err_a, done_a;
    logic [TW-1:0] data_a;
    logic [31:0]   rx_a, mis_a, ord_a;
    logic          start_b, valid_b, ready_b, err_b, done_b;
    logic [TW-1:0] data_b;
    logic [31:0]   rx_b, mis_b, ord_b;
    logic          start_c, valid_c, ready_c, err_c, done_c;
    logic [TW-1:0] data_c;
    logic [31:0]   rx_c, mis_c, ord_c;

    int ncmp  = 0;
    int nfail = 0;

    pkt_sink_checker #(.xcord(1), .ycord(2), .num_of_pckts(48), .READY_PERIOD(0)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .i_data(data_a), .i_valid(valid_a),
        .o_ready(ready_a), .o_rx_count(rx_a), .o_misroute_cnt(mis_a),
        .o_order_err_cnt(ord_a), .o_err(err_a), .o_done(done_a));

    pkt_sink_checker #(.xcord(1), .ycord(2), .num_of_pckts(48), .READY_PERIOD(4)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .i_data(data_b), .i_valid(valid_b),
        .o_ready(ready_b), .o_rx_count(rx_b), .o_misroute_cnt(mis_b),
        .o_order_err_cnt(ord_b), .o_err(err_b), .o_done(done_b));

    pkt_sink_checker #(.xcord(1), .ycord(2), .num_of_pckts(4), .READY_PERIOD(0)) dut_c (
        .clk(clk), .rstn(rstn), .start(start_c), .i_data(data_c), .i_valid(valid_c),
        .o_ready(ready_c), .o_rx_count(rx_c), .o_misroute_cnt(mis_c),
        .o_order_err_cnt(ord_c), .o_err(err_c), .o_done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TW-1:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                         input logic [7:0] sx, input logic [7:0] sy,
                                         input logic [31:0] seq);
        return {208'd0, seq, sy, sx, dy, dx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; start_a = 1'b0; valid_a = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        start_a = 0; valid_a = 0; data_a = '0;
        start_b = 0; valid_b = 0; data_b = '0;
        start_c = 0; valid_c = 0; data_c = '0;
        tick(); tick();

        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_rx",    rx_a,  32'd0);
        check("rst_mis",   mis_a, 32'd0);
        check("rst_ord",   ord_a, 32'd0);
        check("rst_err",   32'(err_a),  32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        rstn = 1'b1;
        tick(); tick();
        check("idle_ready", 32'(ready_a), 32'd0);

        // 48 in-order packets from (0,0), unthrottled
        start_a = 1'b1;
        tick();
        check("run_ready", 32'(ready_a), 32'd1);
        for (int i = 0; i < 48; i++) begin
            valid_a = 1'b1;
            data_a  = mk(2'd1, 2'd2, 8'd0, 8'd0, 32'(i));
            tick();
            if (i == 46) begin
                check("t1_done_early", 32'(done_a), 32'd0);
                check("t1_rx47", rx_a, 32'd47);
            end
        end
        valid_a = 1'b0;
        check("t1_rx",    rx_a, 32'd48);
        check("t1_done",  32'(done_a), 32'd1);
        check("t1_err",   32'(err_a), 32'd0);
        check("t1_ord",   ord_a, 32'd0);
        check("t1_ready_done", 32'(ready_a), 32'd1);

        // Throttle 4, valid held for 40 cycles
        start_b = 1'b1;
        tick();
        for (int k = 0; k < 40; k++) begin
            check("t2_ready", 32'(ready_b), 32'((k % 4) != 3));
            valid_b = 1'b1;
            data_b  = mk(2'd1, 2'd2, 8'd0, 8'd0, 32'(k));
            tick();
        end
        valid_b = 1'b0;
        check("t2_rx",  rx_b, 32'd30);
        check("t2_err", 32'(err_b), 32'd0);

        // num_of_pckts=4, 6 packets sent
        start_c = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            valid_c = 1'b1;
            data_c  = mk(2'd1, 2'd2, 8'd0, 8'd0, 32'(i));
            tick();
            if (i == 2) check("t5_done_early", 32'(done_c), 32'd0);
            if (i == 3) begin
                check("t5_done4", 32'(done_c), 32'd1);
                check("t5_err4",  32'(err_c), 32'd0);
            end
        end
        valid_c = 1'b0;
        check("t5_rx",   rx_c, 32'd6);
        check("t5_done", 32'(done_c), 32'd1);
        check("t5_err",  32'(err_c), 32'd1);

        // Misroute: three packets to (2,2), then one from out-of-range source X=4
        do_reset();
        start_a = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid_a = 1'b1;
            data_a  = mk(2'd2, 2'd2, 8'd0, 8'd0, 32'(i));
            tick();
        end
        valid_a = 1'b0;
        check("t3_mis", mis_a, 32'd3);
        check("t3_err", 32'(err_a), 32'd1);
        check("t3_ord", ord_a, 32'd0);
        check("t3_rx",  rx_a, 32'd3);
        valid_a = 1'b1;
        data_a  = mk(2'd1, 2'd2, 8'd4, 8'd0, 32'd0);
        tick();
        valid_a = 1'b0;
        check("t3_mis_srcx", mis_a, 32'd4);

        // Source (3,3): seq 5,9,9,7,12 back-to-back
        do_reset();
        start_a = 1'b1;
        tick();
        valid_a = 1'b1;
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd5);  tick();
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd9);  tick();
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd9);  tick();
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd7);  tick();
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd12); tick();
        valid_a = 1'b0;
        check("t4_ord", ord_a, SEQ_EN ? 32'd2 : 32'd0);
        check("t4_err", 32'(err_a), SEQ_EN ? 32'd1 : 32'd0);
        check("t4_rx",  rx_a, 32'd5);
        check("t4_mis", mis_a, 32'd0);
        valid_a = 1'b1;
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd12); tick();
        valid_a = 1'b0;
        check("t4_last12", ord_a, SEQ_EN ? 32'd3 : 32'd0);
        valid_a = 1'b1;
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd13); tick();
        valid_a = 1'b0;
        check("t4_seq13", ord_a, SEQ_EN ? 32'd3 : 32'd0);
        check("t4_rx7",   rx_a, 32'd7);

        // Mid-run reset after 10 accepts, then restart
        valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'(20 + i));
            tick();
        end
        valid_a = 1'b0;
        check("t6_rx10", rx_a, 32'd10);
        start_a = 1'b0;
        rstn = 1'b0;
        #3;
        check("t6_async_rx",    rx_a, 32'd0);
        check("t6_async_ready", 32'(ready_a), 32'd0);
        check("t6_async_err",   32'(err_a), 32'd0);
        check("t6_async_ord",   ord_a, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("t6_idle_ready", 32'(ready_a), 32'd0);
        start_a = 1'b1;
        tick();
        valid_a = 1'b1;
        data_a = mk(2'd1, 2'd2, 8'd3, 8'd3, 32'd0);
        tick();
        valid_a = 1'b0;
        check("t6_ord", ord_a, 32'd0);
        check("t6_err", 32'(err_a), 32'd0);
        check("t6_rx",  rx_a, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/pkt_sink_checker.md
# pkt_sink_checker

Receive-side endpoint for NoC traffic tests: attaches to a router's local output port, accepts packets under a programmable ready/valid backpressure pattern, and checks each one. Checks: destination matches this node's coordinates; per-source sequence numbers are strictly increasing. Reports counts and a sticky error flag, and signals done once the expected packet total has arrived. Pairs with the traffic-generating PE on the same node.

## Interface
- xcord, 0, this node's X coordinate
- ycord, 0, this node's Y coordinate
- X, 4, mesh width
- Y, 4, mesh height
- dest_x, 2, destination-X field width
- dest_y, 2, destination-Y field width
- source_x, 8, source-X field width
- source_y, 8, source-Y field width
- data_width, 240, payload width (≥32)
- total_width, dest_x+dest_y+source_x+source_y+data_width, packet width
- num_of_pckts, 48, packets expected before done
- READY_PERIOD, 0, o_ready low one cycle in every READY_PERIOD; 0 = never throttled

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  level; rising edge arms the checker
- i_data  in  total_width  packet: [dest_x-1:0] dst X, next dest_y dst Y, next source_x src X, next source_y src Y, then payload; sequence number = payload bits [31:0]
- i_valid  in  1  packet present
- o_ready  out  1  sink can accept
- o_rx_count  out  32  packets accepted
- o_misroute_cnt  out  32  packets with wrong destination or out-of-range source
- o_order_err_cnt  out  32  sequence-order violations
- o_err  out  1  sticky: any misroute, order error, or overflow
- o_done  out  1  rx_count reached num_of_pckts

## Operation
- FSM states:
  - IDLE (reset state); o_ready=0.
  - RUN: entered on the first clk where start=1 and its registered copy =0.
  - DONE: entered on the edge where the accept brings o_rx_count to num_of_pckts.
- DONE is left only by reset. In DONE, o_ready keeps following the throttle. Any further accept increments o_rx_count and sets o_err (overflow).
- Accept occurs when i_valid & o_ready at a rising edge, in RUN or DONE.
- Per accept:
  - o_rx_count += 1.
  - Misroute check: dst X ≠ xcord, or dst Y ≠ ycord, or src X ≥ X, or src Y ≥ Y. On a hit, o_misroute_cnt += 1 and o_err is set; the packet is not sequence-checked.
  - Otherwise, sequence check against table entry src = srcY*X + srcX, which holds a valid bit and last_seq[31:0]:
    - Entry invalid: store seq, set valid; no error.
    - Entry valid and seq > last_seq (unsigned): store seq.
    - Entry valid and seq ≤ last_seq: o_order_err_cnt += 1, set o_err; table unchanged.
- Gaps in sequence numbers are legal.
- Throttle:
  - Free-running counter tc runs 0..READY_PERIOD-1 and wraps; it is held at 0 in IDLE.
  - o_ready = (state≠IDLE) && (READY_PERIOD==0 || tc≠READY_PERIOD-1).
- All counters saturate at 32'hFFFFFFFF.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - All outputs 0: o_ready, all counters, o_err, o_done.
  - State IDLE; all table valid bits cleared.
- o_ready is derived only from registered state; there is no combinational path from i_valid or i_data.
- Counters, o_err and o_done update on the edge of the accept and are visible the following cycle.
- o_done rises in the same cycle the state shows DONE.
- Back-to-back accepts from the same source on consecutive cycles must check against the just-written seq (table write-then-read forwarding, no stall).
- i_valid with o_ready=0 has no effect. The source holds i_data; the sink does not require it to.
- Reset mid-RUN discards all history; the next run starts from IDLE.
- num_of_pckts=0: DONE is entered on the first RUN cycle.

## Configuration
- PKT_SINK_SEQ_CHECK_EN defined: sequence table and order check present as above.
- Not defined: no table. o_order_err_cnt is tied to 0, and o_err covers only misroute and overflow.

## Test plan
- Reset, then start at cycle 5, READY_PERIOD=0, node (1,2); drive 48 valid packets to (1,2) from source (0,0) with seq 0..47 -> o_ready=1 from cycle 6; o_rx_count=48; o_done=1 the cycle after the 48th accept; o_err=0.
- READY_PERIOD=4, i_valid held high for 40 cycles -> o_ready low every 4th cycle; exactly 30 accepts counted.
- Inject 3 packets addressed to (2,2) at node (1,2) -> o_misroute_cnt=3, o_err=1, o_order_err_cnt=0.
- Source (3,3) sends seq 5, 9, 9, 7, 12 on consecutive cycles -> o_order_err_cnt=2; final stored seq 12. With PKT_SINK_SEQ_CHECK_EN undefined -> o_order_err_cnt=0, o_err=0.
- num_of_pckts=4; send 6 packets -> o_done=1 after the 4th; o_rx_count=6; o_err=1.
- Assert rstn low mid-run after 10 accepts, then release and restart -> all counters 0; a repeated seq 0 from a prior source gives no order error.
